// File: rtl/lcd_i2c_sequencer.sv
// HD44780 4-bit sequencer over a PCF8574 I2C backpack: power-up wait, init ROM, then one user byte at a time.
// cmd_ready is high only in IDLE; each byte is four I2C writes plus a settle delay, and an I2C NACK latches FAULT until reset.
module lcd_i2c_sequencer #(
   parameter logic [6:0] I2C_ADDR  = 7'h27,
   parameter bit         BACKLIGHT = 1'b1,
   parameter int         T_POWERUP = 5_000_000,
   parameter int         T_LONG    = 500_000,
   parameter int         T_SHORT   = 5_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       i2c_ena,
   output logic [6:0] i2c_addr,
   output logic [7:0] i2c_data_wr,
   input  logic       i2c_busy,
   input  logic       i2c_ack_error,
   output logic       init_done,
   output logic       fault
);
   localparam int CW = 24;

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, XFER_REQ, XFER_WAIT, DELAY, FAULT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    rom_idx_q, rom_idx_d;
   logic [1:0]    wr_idx_q, wr_idx_d;
   logic [7:0]    op_byte_q, op_byte_d;
   logic          op_rs_q, op_rs_d;
   logic          op_nib_q, op_nib_d;
   logic          op_long_q, op_long_d;
   logic          init_done_q, init_done_d;
   logic [9:0]    rom_word;
   logic [3:0]    nibble;
   logic [7:0]    image;
   logic [CW-1:0] dly_last;
   logic          last_wr;

   // Init ROM entry: {nibble-only, long delay, byte}; nibble-only entries send just the high nibble.
   always_comb begin
      case (rom_idx_q[2:0])
         3'd0:    rom_word = {1'b1, 1'b1, 8'h30};
         3'd1:    rom_word = {1'b1, 1'b0, 8'h30};
         3'd2:    rom_word = {1'b1, 1'b0, 8'h30};
         3'd3:    rom_word = {1'b1, 1'b0, 8'h20};
         3'd4:    rom_word = {1'b0, 1'b0, 8'h28};
         3'd5:    rom_word = {1'b0, 1'b0, 8'h0C};
         3'd6:    rom_word = {1'b0, 1'b0, 8'h06};
         default: rom_word = {1'b0, 1'b1, 8'h01};
      endcase
   end

   // wr_idx: bit1 selects low nibble, bit0=0 is the E-high strobe write.
   assign nibble   = wr_idx_q[1] ? op_byte_q[3:0] : op_byte_q[7:4];
   assign image    = {nibble, BACKLIGHT, ~wr_idx_q[0], 1'b0, op_rs_q};
   assign last_wr  = (wr_idx_q == {~op_nib_q, 1'b1});
   assign dly_last = op_long_q ? CW'(T_LONG - 1) : CW'(T_SHORT - 1);

   assign i2c_addr    = I2C_ADDR;
   assign i2c_ena     = (state_q == XFER_REQ);
   assign i2c_data_wr = (state_q == XFER_REQ || state_q == XFER_WAIT) ? image : 8'h00;
   assign cmd_ready   = (state_q == IDLE);
   assign fault       = (state_q == FAULT);
   assign init_done   = init_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PWRUP;
         cnt_q       <= '0;
         rom_idx_q   <= '0;
         wr_idx_q    <= '0;
         op_byte_q   <= '0;
         op_rs_q     <= 1'b0;
         op_nib_q    <= 1'b0;
         op_long_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_idx_q   <= rom_idx_d;
         wr_idx_q    <= wr_idx_d;
         op_byte_q   <= op_byte_d;
         op_rs_q     <= op_rs_d;
         op_nib_q    <= op_nib_d;
         op_long_q   <= op_long_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rom_idx_d   = rom_idx_q;
      wr_idx_d    = wr_idx_q;
      op_byte_d   = op_byte_q;
      op_rs_d     = op_rs_q;
      op_nib_d    = op_nib_q;
      op_long_d   = op_long_q;
      init_done_d = init_done_q;
      unique case (state_q)
         PWRUP: begin
            if (cnt_q == CW'(T_POWERUP - 1)) begin
               cnt_d   = '0;
               state_d = INIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         INIT: begin
            if (rom_idx_q == 4'd8) begin
               init_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               op_nib_d  = rom_word[9];
               op_long_d = rom_word[8];
               op_byte_d = rom_word[7:0];
               op_rs_d   = 1'b0;
               wr_idx_d  = 2'd0;
               rom_idx_d = rom_idx_q + 4'd1;
               state_d   = XFER_REQ;
            end
         end
         IDLE: begin
            if (cmd_valid) begin
               op_nib_d  = 1'b0;
               op_rs_d   = cmd_rs;
               op_byte_d = cmd_data;
               op_long_d = !cmd_rs && (cmd_data <= 8'h03);
               wr_idx_d  = 2'd0;
               state_d   = XFER_REQ;
            end
         end
         XFER_REQ: begin
            if (i2c_busy) state_d = XFER_WAIT;
         end
         XFER_WAIT: begin
            if (!i2c_busy) begin
               if (i2c_ack_error) begin
                  state_d = FAULT;
               end else if (last_wr) begin
                  cnt_d   = '0;
                  state_d = DELAY;
               end else begin
                  wr_idx_d = wr_idx_q + 2'd1;
                  state_d  = XFER_REQ;
               end
            end
         end
         DELAY: begin
            if (cnt_q == dly_last) begin
               cnt_d   = '0;
               state_d = init_done_q ? IDLE : INIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = PWRUP;
      endcase
   end
endmodule
